// File: rtl/demux_rr_n.sv
// demux_rr_n: parametrised 1-to-NUM_OUT demultiplexer for the receive datapath.
// One valid/ready input stream is distributed over NUM_OUT one-entry lane
// registers, either round-robin (modo=0) or steered by sel_entrada (modo=1).
// Each lane pops independently through its own ready_salida bit.
// Optional feature macro: DEMUX_STALL_CNT_EN adds a saturating stall counter
// output cnt_stall[15:0]. The default build leaves it out.
module demux_rr_n #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_OUT = 4,
  localparam int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk_f,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         entrada,
  input  logic                     valid_entrada,
  output logic                     ready_entrada,
  input  logic                     modo,
  input  logic [SEL_W-1:0]         sel_entrada,
  output logic [NUM_OUT*WIDTH-1:0] salida,
  output logic [NUM_OUT-1:0]       valid_salida,
  input  logic [NUM_OUT-1:0]       ready_salida,
  output logic [SEL_W-1:0]         ptr_rr
`ifdef DEMUX_STALL_CNT_EN
  ,
  output logic [15:0]              cnt_stall
`endif
);

  // Lane storage: packed so lane i sits at bits [i*WIDTH +: WIDTH].
  logic [NUM_OUT-1:0][WIDTH-1:0] data_q;
  logic [NUM_OUT-1:0][WIDTH-1:0] data_d;
  logic [NUM_OUT-1:0]            valid_q;
  logic [NUM_OUT-1:0]            valid_d;
  logic [SEL_W-1:0]              ptr_q;
  logic [SEL_W-1:0]              ptr_d;

  logic [SEL_W-1:0]              target_s;
  logic [NUM_OUT-1:0]            pop_s;
  logic                          ready_in_s;
  logic                          accept_s;

  // Target lane selection, per-lane pop and input handshake.
  // ready_in_s is combinational from modo/sel_entrada/ready_salida so a lane
  // being drained can be refilled in the same cycle.
  always_comb begin
    target_s   = ptr_q;
    pop_s      = valid_q & ready_salida;
    ready_in_s = 1'b0;
    accept_s   = 1'b0;
    if (modo) begin
      target_s = sel_entrada;
    end else begin
      target_s = ptr_q;
    end
    ready_in_s = ~valid_q[target_s] | ready_salida[target_s];
    accept_s   = valid_entrada & ready_in_s;
  end

  // Next lane contents: pops clear valid, an accepted word loads the target
  // lane (overriding a simultaneous pop). Popped data is left in place.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~pop_s;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (accept_s && (target_s == SEL_W'(i))) begin
        data_d[i]  = entrada;
        valid_d[i] = 1'b1;
      end else begin
        data_d[i]  = data_q[i];
      end
    end
  end

  // Round-robin pointer advances only on accepted words in round-robin mode;
  // NUM_OUT is a power of two so the natural wrap of SEL_W bits is exact.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_s && !modo) begin
      ptr_d = ptr_q + SEL_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Lane and pointer state registers; reset discards any held words.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ready_entrada = ready_in_s;
  assign salida        = data_q;
  assign valid_salida  = valid_q;
  assign ptr_rr        = ptr_q;

`ifdef DEMUX_STALL_CNT_EN
  logic [15:0] cnt_stall_q;
  logic [15:0] cnt_stall_d;

  // Count cycles where the source offers a word that cannot be taken,
  // saturating at all-ones.
  always_comb begin
    cnt_stall_d = cnt_stall_q;
    if (valid_entrada && !ready_in_s && (cnt_stall_q != 16'hFFFF)) begin
      cnt_stall_d = cnt_stall_q + 16'd1;
    end else begin
      cnt_stall_d = cnt_stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      cnt_stall_q <= 16'h0000;
    end else begin
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign cnt_stall = cnt_stall_q;
`endif

endmodule

// File: tb/tb_demux_rr_n.sv
// Self-checking bench for demux_rr_n (WIDTH=8, NUM_OUT=4).
// Table of directed vectors plus hand-written reset and stall sequences.
// Define DEMUX_STALL_CNT_EN for both files to exercise the stall counter.
module tb_demux_rr_n;

  logic        clk_f = 1'b0;
  logic        reset;
  logic [7:0]  entrada;
  logic        valid_entrada;
  logic        ready_entrada;
  logic        modo;
  logic [1:0]  sel_entrada;
  logic [31:0] salida;
  logic [3:0]  valid_salida;
  logic [3:0]  ready_salida;
  logic [1:0]  ptr_rr;
`ifdef DEMUX_STALL_CNT_EN
  logic [15:0] cnt_stall;
`endif

  demux_rr_n #(.WIDTH(8), .NUM_OUT(4)) dut (
    .clk_f         (clk_f),
    .reset         (reset),
    .entrada       (entrada),
    .valid_entrada (valid_entrada),
    .ready_entrada (ready_entrada),
    .modo          (modo),
    .sel_entrada   (sel_entrada),
    .salida        (salida),
    .valid_salida  (valid_salida),
    .ready_salida  (ready_salida),
    .ptr_rr        (ptr_rr)
`ifdef DEMUX_STALL_CNT_EN
    ,
    .cnt_stall     (cnt_stall)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk_f = ~clk_f;

  typedef struct {
    logic        vin;
    logic [7:0]  din;
    logic        m;
    logic [1:0]  sel;
    logic [3:0]  rdy;
    logic        exp_rin;
    logic [3:0]  exp_vout;
    logic [1:0]  exp_ptr;
    logic [31:0] exp_sal;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic vin, input logic [7:0] din, input logic m,
                              input logic [1:0] sel, input logic [3:0] rdy,
                              input logic exp_rin, input logic [3:0] exp_vout,
                              input logic [1:0] exp_ptr, input logic [31:0] exp_sal);
    vec_t v;
    v.vin = vin; v.din = din; v.m = m; v.sel = sel; v.rdy = rdy;
    v.exp_rin = exp_rin; v.exp_vout = exp_vout; v.exp_ptr = exp_ptr; v.exp_sal = exp_sal;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check the handshake before the
  // rising edge and the registered state just after it.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk_f);
    valid_entrada = v.vin;
    entrada       = v.din;
    modo          = v.m;
    sel_entrada   = v.sel;
    ready_salida  = v.rdy;
    #1;
    check($sformatf("v%0d ready_entrada", idx), {31'd0, ready_entrada}, {31'd0, v.exp_rin});
    @(posedge clk_f);
    #1;
    check($sformatf("v%0d valid_salida", idx), {28'd0, valid_salida}, {28'd0, v.exp_vout});
    check($sformatf("v%0d ptr_rr", idx), {30'd0, ptr_rr}, {30'd0, v.exp_ptr});
    check($sformatf("v%0d salida", idx), salida, v.exp_sal);
  endtask

  initial begin
    // Round-robin full rate, all lanes ready
    vecs.push_back(mk(1'b1, 8'h10, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 2'd1, 32'h00000010));
    vecs.push_back(mk(1'b1, 8'h11, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 2'd2, 32'h00001110));
    vecs.push_back(mk(1'b1, 8'h12, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 2'd3, 32'h00121110));
    vecs.push_back(mk(1'b1, 8'h13, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 2'd0, 32'h13121110));
    vecs.push_back(mk(1'b1, 8'h14, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 2'd1, 32'h13121114));
    vecs.push_back(mk(1'b1, 8'h15, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 2'd2, 32'h13121514));
    vecs.push_back(mk(1'b1, 8'h16, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 2'd3, 32'h13161514));
    vecs.push_back(mk(1'b1, 8'h17, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 2'd0, 32'h17161514));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd0, 32'h17161514));
    // Backpressure on lane 1
    vecs.push_back(mk(1'b1, 8'hA0, 1'b0, 2'd0, 4'b1101, 1'b1, 4'b0001, 2'd1, 32'h171615A0));
    vecs.push_back(mk(1'b1, 8'hA1, 1'b0, 2'd0, 4'b1101, 1'b1, 4'b0010, 2'd2, 32'h1716A1A0));
    vecs.push_back(mk(1'b1, 8'hA2, 1'b0, 2'd0, 4'b1101, 1'b1, 4'b0110, 2'd3, 32'h17A2A1A0));
    vecs.push_back(mk(1'b1, 8'hA3, 1'b0, 2'd0, 4'b1101, 1'b1, 4'b1010, 2'd0, 32'hA3A2A1A0));
    vecs.push_back(mk(1'b1, 8'hA4, 1'b0, 2'd0, 4'b1101, 1'b1, 4'b0011, 2'd1, 32'hA3A2A1A4));
    vecs.push_back(mk(1'b1, 8'hA5, 1'b0, 2'd0, 4'b1101, 1'b0, 4'b0010, 2'd1, 32'hA3A2A1A4));
    vecs.push_back(mk(1'b1, 8'hA5, 1'b0, 2'd0, 4'b1101, 1'b0, 4'b0010, 2'd1, 32'hA3A2A1A4));
    vecs.push_back(mk(1'b1, 8'hA5, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 2'd2, 32'hA3A2A5A4));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd2, 32'hA3A2A5A4));
    // Steered to lane 3, then blocked steer, then back to round-robin
    vecs.push_back(mk(1'b1, 8'h55, 1'b1, 2'd3, 4'b1111, 1'b1, 4'b1000, 2'd2, 32'h55A2A5A4));
    vecs.push_back(mk(1'b1, 8'h66, 1'b1, 2'd3, 4'b1111, 1'b1, 4'b1000, 2'd2, 32'h66A2A5A4));
    vecs.push_back(mk(1'b1, 8'h77, 1'b1, 2'd3, 4'b0111, 1'b0, 4'b1000, 2'd2, 32'h66A2A5A4));
    vecs.push_back(mk(1'b1, 8'h88, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b1100, 2'd3, 32'h6688A5A4));
    vecs.push_back(mk(1'b1, 8'h99, 1'b0, 2'd0, 4'b0111, 1'b0, 4'b1000, 2'd3, 32'h6688A5A4));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd3, 32'h6688A5A4));
    // Set up lanes 0 and 2 full with ptr_rr=2
    vecs.push_back(mk(1'b1, 8'hC3, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b1000, 2'd0, 32'hC388A5A4));
    vecs.push_back(mk(1'b1, 8'hC0, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0001, 2'd1, 32'hC388A5C0));
    vecs.push_back(mk(1'b1, 8'hC1, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0011, 2'd2, 32'hC388C1C0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0001, 2'd2, 32'hC388C1C0));
    vecs.push_back(mk(1'b1, 8'hC2, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0101, 2'd2, 32'hC3C2C1C0));

    // Reset held with random inputs
    reset         = 1'b0;
    valid_entrada = 1'b0;
    entrada       = 8'h00;
    modo          = 1'b0;
    sel_entrada   = 2'd0;
    ready_salida  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_f);
      valid_entrada = 1'($urandom_range(0, 1));
      entrada       = 8'($urandom_range(0, 255));
      modo          = 1'($urandom_range(0, 1));
      sel_entrada   = 2'($urandom_range(0, 3));
      ready_salida  = 4'($urandom_range(0, 15));
      @(posedge clk_f);
      #1;
      check("reset valid_salida", {28'd0, valid_salida}, 32'd0);
      check("reset ptr_rr", {30'd0, ptr_rr}, 32'd0);
      check("reset salida", salida, 32'd0);
      check("reset ready_entrada", {31'd0, ready_entrada}, 32'd1);
    end
    @(negedge clk_f);
    valid_entrada = 1'b0;
    ready_salida  = 4'b0000;
    modo          = 1'b0;
    reset         = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], i);
    end

    // Asynchronous reset mid-operation: lanes 0 and 2 full, ptr_rr=2
    @(negedge clk_f);
    valid_entrada = 1'b1;
    entrada       = 8'hEE;
    modo          = 1'b0;
    ready_salida  = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    check("async rst valid_salida", {28'd0, valid_salida}, 32'd0);
    check("async rst ptr_rr", {30'd0, ptr_rr}, 32'd0);
    check("async rst salida", salida, 32'd0);
    check("async rst ready_entrada", {31'd0, ready_entrada}, 32'd1);
    @(posedge clk_f);
    #1;
    check("in rst write ignored", {28'd0, valid_salida}, 32'd0);
    @(negedge clk_f);
    reset   = 1'b1;
    entrada = 8'hD0;
    #1;
    check("post rst ready_entrada", {31'd0, ready_entrada}, 32'd1);
    @(posedge clk_f);
    #1;
    check("post rst valid_salida", {28'd0, valid_salida}, 32'd1);
    check("post rst salida", salida, 32'h000000D0);
    check("post rst ptr_rr", {30'd0, ptr_rr}, 32'd1);

`ifdef DEMUX_STALL_CNT_EN
    // Stall against full, blocked lane 0
    @(negedge clk_f);
    modo          = 1'b1;
    sel_entrada   = 2'd0;
    entrada       = 8'hE0;
    valid_entrada = 1'b1;
    ready_salida  = 4'b0000;
    repeat (10) @(posedge clk_f);
    #1;
    check("cnt_stall 10", {16'd0, cnt_stall}, 32'd10);
    repeat (70000) @(posedge clk_f);
    #1;
    check("cnt_stall saturate", {16'd0, cnt_stall}, 32'h0000FFFF);
`endif

    @(negedge clk_f);
    valid_entrada = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
